// File: rtl/fb_pkg.sv
// Shared types and default sizing for the frame-buffer write path.
// No logic; imported by fb_wr_ctrl and fb_fifo.
// No flow control of its own.
package fb_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_ADDR_WIDTH   = 29;
  localparam int DEF_FRAME_PIXELS = 307200;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } wr_state_t;

endpackage

// File: rtl/fb_fifo.sv
// Synchronous FIFO with registered full/empty flags; head entry visible on rd_dat.
// Latency: an entry written on one edge can be popped on the next edge.
// Backpressure: writes while full and reads while empty are ignored.
module fb_fifo
  import fb_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = wr_en & ~full;
  assign do_pop  = rd_en & ~empty;
  assign rd_dat  = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    if (do_push && !do_pop) begin
      cnt_nxt = cnt + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == FULL_CNT);
      empty <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/fb_wr_ctrl.sv
// Pixel stream to SRAM-style writes: each word held 3 cycles (2 with wr_en_n low), frame-relative addressing.
// Latency: pixel accepted on edge N drives mem_wr_en_n low after edge N+1 at the earliest.
// Backpressure: pix_ready drops when the FIFO is full; FB_WR_CTRL_STATS_EN adds frame/drop counters.
module fb_wr_ctrl
  import fb_pkg::*;
#(
  parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int                    FRAME_PIXELS = DEF_FRAME_PIXELS,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en_n,
  output logic                  mem_rd_en_n,
  output logic                  frame_done,
  output logic                  err_short,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int               PTR_W    = $clog2(FRAME_PIXELS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_PIXELS - 1);

  logic                  ready_q;
  logic                  synced;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_dat;
  logic                  pop_sof;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_eff;
  logic                  last_q;
  wr_state_t             state;

  // ready_q keeps pix_ready low for the cycle right after reset
  assign pix_ready   = ready_q & ~fifo_full;
  assign accept      = pix_valid & pix_ready;
  assign push        = accept & (synced | pix_sof);
  assign pop         = ((state == ST_IDLE) | (state == ST_RELEASE)) & ~fifo_empty;
  assign pop_sof     = fifo_dat[DATA_WIDTH];
  assign ptr_eff     = pop_sof ? '0 : ptr;
  assign mem_rd_en_n = 1'b1;

  fb_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (push),
    .wr_dat ({pix_sof, pix_data}),
    .rd_en  (pop),
    .rd_dat (fifo_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      synced  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (accept && pix_sof) synced <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      mem_wr_en_n <= 1'b1;
      mem_wr_addr <= BASE_ADDR;
      mem_wr_data <= '0;
      ptr         <= '0;
      last_q      <= 1'b0;
      frame_done  <= 1'b0;
      err_short   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      case (state)
        ST_IDLE, ST_RELEASE: begin
          if (!fifo_empty) begin
            state       <= ST_ASSERT;
            mem_wr_en_n <= 1'b0;
            mem_wr_addr <= BASE_ADDR + ADDR_WIDTH'(ptr_eff);
            mem_wr_data <= fifo_dat[DATA_WIDTH-1:0];
            err_short   <= pop_sof && (ptr != '0);
            last_q      <= (ptr_eff == LAST_PTR);
            ptr         <= (ptr_eff == LAST_PTR) ? '0 : ptr_eff + 1'b1;
          end else begin
            state       <= ST_IDLE;
            mem_wr_en_n <= 1'b1;
          end
        end
        ST_ASSERT: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          state       <= ST_RELEASE;
          mem_wr_en_n <= 1'b1;
          frame_done  <= last_q;
        end
      endcase
    end
  end

`ifdef FB_WR_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (frame_done) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (accept && !pix_sof && !synced && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  assign frame_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_fb_wr_ctrl.sv
// Bench for fb_wr_ctrl (FRAME_PIXELS=4, BASE_ADDR=0x100): directed scenarios plus random traffic
// against a queue-based reference of the write stream.
module tb_fb_wr_ctrl;

  localparam int          DW    = 32;
  localparam int          AW    = 29;
  localparam int          FP    = 4;
  localparam int          DEPTH = 4;
  localparam logic [28:0] BASE  = 29'h100;
`ifdef FB_WR_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_sof;
  logic          pix_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_en_n;
  logic          mem_rd_en_n;
  logic          frame_done;
  logic          err_short;
  logic [15:0]   frame_cnt;
  logic [15:0]   drop_cnt;

  fb_wr_ctrl #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .FRAME_PIXELS (FP),
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_sof     (pix_sof),
    .pix_ready   (pix_ready),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en_n (mem_wr_en_n),
    .mem_rd_en_n (mem_rd_en_n),
    .frame_done  (frame_done),
    .err_short   (err_short),
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: stored pixels wait in a queue; a write slot lasts 3 cycles
  // (t=0,1 enable low, t=2 release) and the next word starts right after.
  typedef struct {
    logic [DW-1:0] d;
    logic          sof;
  } ent_t;

  ent_t        q[$];
  int          t = 3;
  bit          m_on = 0;
  logic        m_ready;
  bit          m_synced;
  int          m_ptr;
  logic [28:0] m_addr;
  logic [31:0] m_data;
  bit          m_err_cur;
  bit          m_last_cur;
  int          m_fc;
  int          m_dc;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      t = 3; m_ready = 0; m_synced = 0; m_ptr = 0;
      m_addr = BASE; m_data = 0; m_err_cur = 0; m_last_cur = 0;
      m_fc = 0; m_dc = 0; m_on = 1;
    end else if (m_on) begin
      bit   acc;
      bit   start;
      int   eff;
      ent_t e;
      acc = pix_valid && m_ready;
      if (t == 2 && m_last_cur) m_fc = (m_fc + 1) % 65536;
      if (acc && !pix_sof && !m_synced && m_dc < 65535) m_dc++;
      start = (t >= 2) && (q.size() > 0);
      if (start) e = q.pop_front();
      if (acc && (m_synced || pix_sof)) q.push_back('{pix_data, pix_sof});
      if (acc && pix_sof) m_synced = 1;
      if (start) begin
        eff        = e.sof ? 0 : m_ptr;
        m_err_cur  = e.sof && (m_ptr != 0);
        m_addr     = BASE + 29'(eff);
        m_data     = e.d;
        m_last_cur = (eff == FP - 1);
        m_ptr      = m_last_cur ? 0 : eff + 1;
        t          = 0;
      end else if (t < 3) begin
        t++;
      end
      m_ready = (q.size() < DEPTH);
    end
  end

  // Observed write log and pulse counts for the directed checks.
  logic [28:0] wa[$];
  logic [31:0] wd[$];
  int          done_cnt;
  int          err_cnt;
  bit          saw_nr;
  logic        prev_en_n = 1'b1;
  int          low_run = 0;
  int          last_low = 0;

  always @(negedge clk) begin
    if (m_on) begin
      chk("pix_ready", pix_ready, m_ready);
      chk("wr_en_n", mem_wr_en_n, !(t < 2));
      chk("wr_addr", mem_wr_addr, m_addr);
      chk("wr_data", mem_wr_data, m_data);
      chk("rd_en_n", mem_rd_en_n, 1'b1);
      chk("frame_done", frame_done, (t == 2) && m_last_cur);
      chk("err_short", err_short, (t == 0) && m_err_cur);
      chk("frame_cnt", frame_cnt, STATS ? m_fc : 0);
      chk("drop_cnt", drop_cnt, STATS ? m_dc : 0);
    end
    if (mem_wr_en_n === 1'b0 && prev_en_n === 1'b1) begin
      wa.push_back(mem_wr_addr);
      wd.push_back(mem_wr_data);
    end
    if (mem_wr_en_n === 1'b0) low_run++;
    else if (low_run != 0) begin last_low = low_run; low_run = 0; end
    if (frame_done === 1'b1) done_cnt++;
    if (err_short === 1'b1) err_cnt++;
    if (pix_ready === 1'b0 && reset === 1'b0) saw_nr = 1;
    prev_en_n = mem_wr_en_n;
  end

  task automatic clr();
    wa.delete(); wd.delete();
    done_cnt = 0; err_cnt = 0; saw_nr = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic s);
    int   n;
    logic acc;
    pix_valid = 1'b1; pix_data = d; pix_sof = s; n = 0;
    do begin
      acc = pix_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    chk("send_accept", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0; pix_sof = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pix_valid = 1'b0; pix_sof = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", pix_ready, 1'b0);
    chk("rst_en_n", mem_wr_en_n, 1'b1);
    chk("rst_addr", mem_wr_addr, 29'h100);
    chk("rst_data", mem_wr_data, 32'h0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_err", err_short, 1'b0);
    chk("rst_fcnt", frame_cnt, 16'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", pix_ready, 1'b1);

    // pixels before any SOF are discarded
    clr();
    send(32'h11, 1'b0);
    send(32'h12, 1'b0);
    idle(10);
    chk("unsync_writes", wa.size(), 0);
    chk("unsync_drop_cnt", drop_cnt, STATS ? 2 : 0);

    // one full frame back-to-back
    do_reset(); clr();
    send(32'hA0, 1'b1);
    for (int i = 1; i < 4; i++) send(32'hA0 + i, 1'b0);
    idle(20);
    chk("frame_nwr", wa.size(), 4);
    for (int i = 0; i < wa.size() && i < 4; i++) begin
      chk("frame_addr", wa[i], 29'h100 + i);
      chk("frame_data", wd[i], 32'hA0 + i);
    end
    chk("frame_done_cnt", done_cnt, 1);
    chk("frame_low_run", last_low, 2);

    // SOF arriving after two words of a frame
    do_reset(); clr();
    send(32'hB0, 1'b1);
    send(32'hB1, 1'b0);
    send(32'hC0, 1'b1);
    idle(20);
    chk("short_err_cnt", err_cnt, 1);
    chk("short_nwr", wa.size(), 3);
    if (wa.size() == 3) chk("short_restart_addr", wa[2], 29'h100);

    // ten pixels continuous: FIFO fills, nothing lost, address wraps
    do_reset(); clr();
    send(32'hD0, 1'b1);
    for (int i = 1; i < 10; i++) send(32'hD0 + i, 1'b0);
    idle(40);
    chk("burst_backpressure", saw_nr, 1'b1);
    chk("burst_nwr", wa.size(), 10);
    for (int i = 0; i < wa.size() && i < 10; i++) begin
      chk("burst_addr", wa[i], 29'h100 + (i % 4));
      chk("burst_data", wd[i], 32'hD0 + i);
    end
    chk("burst_done_cnt", done_cnt, 2);

    // reset during HOLD drops the in-flight word
    do_reset(); clr();
    send(32'hE0, 1'b1);
    pix_valid = 1'b0; pix_sof = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("hold_en_n", mem_wr_en_n, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("hold_rst_en_n", mem_wr_en_n, 1'b1);
    chk("hold_rst_addr", mem_wr_addr, 29'h100);
    reset = 1'b0;
    idle(10);
    chk("hold_rst_nwr", wa.size(), 1);

    // random traffic with occasional resets
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      reset     = ($urandom_range(0, 399) == 0);
      pix_valid = ($urandom_range(0, 99) < 70);
      pix_data  = $urandom;
      pix_sof   = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_wr_ctrl.md
FB_WR_CTRL -- requirements
Module: fb_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, pixel/memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, 29, memory address width.
REQ-003 SHALL have parameter FRAME_PIXELS, 307200, words per frame; legal range 2..2^ADDR_WIDTH-BASE_ADDR.
REQ-004 SHALL have parameter BASE_ADDR, 0, frame start address.
REQ-005 SHALL have parameter FIFO_DEPTH, 4, input buffer entries, power of two.
REQ-006 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port pix_data  in  DATA_WIDTH  pixel word.
REQ-009 SHALL have port pix_valid  in  1  pixel present.
REQ-010 SHALL have port pix_sof  in  1  pixel is first of a frame, qualified by pix_valid.
REQ-011 SHALL have port pix_ready  out  1  block can accept pixel.
REQ-012 SHALL have port mem_wr_addr  out  ADDR_WIDTH  memory write address.
REQ-013 SHALL have port mem_wr_data  out  DATA_WIDTH  memory write data.
REQ-014 SHALL have port mem_wr_en_n  out  1  write enable, active-low.
REQ-015 SHALL have port mem_rd_en_n  out  1  read enable, active-low, constant 1.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse, last word of frame written.
REQ-017 SHALL have port err_short  out  1  one-cycle pulse, SOF arrived mid-frame.
REQ-018 SHALL have ports frame_cnt, drop_cnt  out  16 each  statistics (REQ-033).

Function
REQ-019 Pixel accepted when pix_valid && pix_ready; pix_ready = FIFO not full, registered.
REQ-020 Accepted {pix_data, pix_sof} SHALL enter FIFO; FIFO is the only buffering.
REQ-021 Until first SOF after reset (unsynced), accepted non-SOF pixels SHALL be dropped, not stored.
REQ-022 FSM states IDLE, ASSERT, HOLD, RELEASE; IDLE->ASSERT when FIFO non-empty, popping one entry into mem_wr_addr/mem_wr_data.
REQ-023 ASSERT->HOLD->RELEASE unconditionally; mem_wr_en_n=0 in ASSERT and HOLD, 1 in IDLE and RELEASE; addr/data stable ASSERT through RELEASE.
REQ-024 RELEASE->ASSERT (pop) if FIFO non-empty, else IDLE; sustained throughput one word per 3 cycles.
REQ-025 Write pointer ptr 0..FRAME_PIXELS-1; mem_wr_addr = BASE_ADDR + ptr; ptr increments after each write.
REQ-026 Popped SOF entry SHALL force ptr=0 for that word; if ptr!=0 at that point, err_short pulses in ASSERT.
REQ-027 Write at ptr=FRAME_PIXELS-1 SHALL pulse frame_done in its RELEASE cycle and wrap ptr to 0.
REQ-028 Consecutive writes therefore always differ in address (FRAME_PIXELS>=2).
REQ-029 Simultaneous push and pop SHALL both occur; count unchanged.

Reset
REQ-030 On reset: FIFO empty, pix_ready=0 for that cycle then 1, state IDLE, mem_wr_en_n=1, mem_rd_en_n=1, mem_wr_addr=BASE_ADDR, mem_wr_data=0, ptr=0, unsynced, frame_done=0, err_short=0, counters 0.
REQ-031 Reset during ASSERT/HOLD SHALL deassert mem_wr_en_n the following cycle; in-flight word discarded.
REQ-032 Reset SHALL NOT depend on clk-asynchronous paths.

Configuration
REQ-033 Macro FB_WR_CTRL_STATS_EN defined: frame_cnt increments on frame_done (wraps); drop_cnt counts REQ-021 drops (saturates at 0xFFFF). Undefined: both outputs constant 0, no counter logic.

Structure
REQ-034 Package fb_pkg SHALL hold FSM state typedef, default DATA_WIDTH/ADDR_WIDTH/FRAME_PIXELS constants.
REQ-035 FIFO SHALL be sub-module fb_fifo (sync, full/empty flags, registered outputs).

Verification (FRAME_PIXELS=4, BASE_ADDR=0x100)
REQ-036 Reset then 4 pixels SOF+0xA0..0xA3 back-to-back -> writes 0x100..0x103, each mem_wr_en_n low 2 cycles, 1 high; frame_done once.
REQ-037 Pixels 0x11,0x12 before any SOF -> no write, drop_cnt=2 (stats on) / 0 (off).
REQ-038 SOF after 2 words of frame -> err_short pulse, next write at 0x100.
REQ-039 10 pixels continuous valid -> pix_ready drops after 4 buffered, no loss, addresses wrap 0x103->0x100.
REQ-040 Reset asserted in HOLD -> mem_wr_en_n=1 next cycle, addr=0x100, FIFO empty.
